// File: rtl/shape_pkg.sv
// rtl/shape_pkg.sv - shared shape geometry, display timing defaults and fetch FSM states
package shape_pkg;

  localparam int SHAPE_WIDTH  = 51;
  localparam int SHAPE_HEIGHT = 60;
  localparam int SHAPE_ADDR_W = 6;
  localparam int ORIENT_W     = 4;

  localparam int DEF_CW       = 11;
  localparam int DEF_V_TOTAL  = 525;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_ROM_LAT  = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/shape_row_serializer.sv
// rtl/shape_row_serializer.sv - line buffer and per-pixel serialiser for one shape row
// Optional horizontal flip under SHAPE_ROW_RENDER_MIRROR_EN.
module shape_row_serializer
  import shape_pkg::*;
#(
  parameter int WIDTH    = SHAPE_WIDTH,
  parameter int CW       = DEF_CW,
  parameter int H_ACTIVE = DEF_H_ACTIVE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] row_data,
  input  logic [CW-1:0]    hcount,
  input  logic [CW-1:0]    pos_x,
`ifdef SHAPE_ROW_RENDER_MIRROR_EN
  input  logic             mirror,
`endif
  output logic             pixel_on
);

  localparam int IW = $clog2(WIDTH);
  localparam int WM1 = WIDTH - 1;
  localparam logic [CW:0]   W_EXT = WIDTH[CW:0];
  localparam logic [IW-1:0] IDX_MAX = WM1[IW-1:0];
  localparam logic [CW-1:0] H_LIM = H_ACTIVE[CW-1:0];

  logic [WIDTH-1:0] row_buf;
  logic [CW:0]      hx;
  logic [CW:0]      x_lo;
  logic [CW:0]      x_hi;
  logic             in_x;
  logic [IW-1:0]    col;
  logic [IW-1:0]    idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_buf <= '0;
    end else if (clear) begin
      row_buf <= '0;
    end else if (load) begin
      row_buf <= row_data;
    end
  end

  // Extra bit on the span end keeps sprites near the right edge from wrapping.
  always_comb begin
    hx   = {1'b0, hcount};
    x_lo = {1'b0, pos_x};
    x_hi = x_lo + W_EXT;
    in_x = (hx >= x_lo) && (hx < x_hi);
    col  = IW'(hcount - pos_x);
    idx  = IDX_MAX - col;
`ifdef SHAPE_ROW_RENDER_MIRROR_EN
    if (mirror) idx = col;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_on <= 1'b0;
    end else begin
      pixel_on <= in_x && (hcount < H_LIM) && row_buf[idx];
    end
  end

endmodule

// File: rtl/shape_row_renderer.sv
// rtl/shape_row_renderer.sv - hblank shape row fetch FSM, frame latch and pixel output
// Optional mirror_x input and horizontal flip under SHAPE_ROW_RENDER_MIRROR_EN.
module shape_row_renderer
  import shape_pkg::*;
#(
  parameter int WIDTH    = SHAPE_WIDTH,
  parameter int HEIGHT   = SHAPE_HEIGHT,
  parameter int CW       = DEF_CW,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int ROM_LAT  = DEF_ROM_LAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    line_start,
  input  logic [CW-1:0]           hcount,
  input  logic [CW-1:0]           vcount,
  input  logic [CW-1:0]           pos_x,
  input  logic [CW-1:0]           pos_y,
  input  logic [ORIENT_W-1:0]     orientation_in,
  input  logic                    sprite_en,
`ifdef SHAPE_ROW_RENDER_MIRROR_EN
  input  logic                    mirror_x,
`endif
  output logic [ORIENT_W-1:0]     rom_orientation,
  output logic [SHAPE_ADDR_W-1:0] rom_address,
  input  logic [WIDTH-1:0]        rom_data,
  output logic                    pixel_on,
  output logic                    busy,
  output logic                    overrun
);

  localparam int CNT_W  = (ROM_LAT < 2) ? 1 : $clog2(ROM_LAT + 1);
  localparam int V_LAST_I = V_TOTAL - 1;
  localparam logic [CW-1:0]    V_LAST   = V_LAST_I[CW-1:0];
  localparam logic [CW-1:0]    HEIGHT_C = HEIGHT[CW-1:0];
  localparam logic [CNT_W-1:0] LAT_C    = ROM_LAT[CNT_W-1:0];

  logic [CW-1:0]           pos_x_l;
  logic [CW-1:0]           pos_y_l;
  logic [ORIENT_W-1:0]     orient_l;
  logic                    en_l;
`ifdef SHAPE_ROW_RENDER_MIRROR_EN
  logic                    mirror_l;
`endif

  logic [CW-1:0]           pos_y_eff;
  logic                    en_eff;
  logic [CW-1:0]           nl;
  logic [CW:0]             row;
  logic                    in_range;

  fetch_state_t            state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SHAPE_ADDR_W-1:0] fetch_row;
  logic                    buf_load;
  logic                    buf_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_l  <= '0;
      pos_y_l  <= '0;
      orient_l <= '0;
      en_l     <= 1'b0;
`ifdef SHAPE_ROW_RENDER_MIRROR_EN
      mirror_l <= 1'b0;
`endif
    end else if (frame_start) begin
      pos_x_l  <= pos_x;
      pos_y_l  <= pos_y;
      orient_l <= orientation_in;
      en_l     <= sprite_en;
`ifdef SHAPE_ROW_RENDER_MIRROR_EN
      mirror_l <= mirror_x;
`endif
    end
  end

  // A fetch launched in the frame_start cycle must already see the new frame's values.
  always_comb begin
    pos_y_eff = frame_start ? pos_y : pos_y_l;
    en_eff    = frame_start ? sprite_en : en_l;
    nl        = (vcount == V_LAST) ? '0 : vcount + 1'b1;
    row       = {1'b0, nl} - {1'b0, pos_y_eff};
    in_range  = en_eff && !row[CW] && (row[CW-1:0] < HEIGHT_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fetch_row   <= '0;
      rom_address <= '0;
      overrun     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && line_start) fetch_row <= row[SHAPE_ADDR_W-1:0];
      if (state_q == ISSUE) rom_address <= fetch_row;
      if (state_q != IDLE && line_start) overrun <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_start) begin
          if (in_range) state_d = ISSUE;
          else          buf_clear = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = LAT_C;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        buf_load = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy            = (state_q != IDLE);
  assign rom_orientation = orient_l;

  shape_row_serializer #(
    .WIDTH    (WIDTH),
    .CW       (CW),
    .H_ACTIVE (H_ACTIVE)
  ) u_serializer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (buf_load),
    .clear    (buf_clear),
    .row_data (rom_data),
    .hcount   (hcount),
    .pos_x    (pos_x_l),
`ifdef SHAPE_ROW_RENDER_MIRROR_EN
    .mirror   (mirror_l),
`endif
    .pixel_on (pixel_on)
  );

endmodule

// File: doc/shape_row_renderer.md
Name: shape_row_renderer

Overview:
- Downstream consumer of the per-orientation shape bitmap ROMs (51-bit row per 6-bit address, 1-cycle registered-address latency).
- During each horizontal blank it fetches the shape row needed by the next scan line into a line buffer.
- During the active region it serialises that row into a per-pixel `pixel_on` for the display mixer.
- Sprite position and orientation are frame-latched so a sprite never tears mid-frame.

Parameters:
- WIDTH, 51, shape row width in pixels (ROM data width).
- HEIGHT, 60, shape rows (valid ROM addresses 0..HEIGHT-1).
- CW, 11, width of screen counters and positions.
- V_TOTAL, 525, total lines per frame (vertical wrap point).
- H_ACTIVE, 640, visible pixels per line; no output at or beyond it.
- ROM_LAT, 1, cycles from `rom_address` change to valid `rom_data`.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse, first cycle of vertical blank
- line_start  in  1  one-cycle pulse, first cycle of horizontal blank of line `vcount`
- hcount  in  CW  current pixel column
- vcount  in  CW  current line
- pos_x  in  CW  sprite left column (sampled on `frame_start`)
- pos_y  in  CW  sprite top line (sampled on `frame_start`)
- orientation_in  in  4  shape orientation (sampled on `frame_start`)
- sprite_en  in  1  draw enable (sampled on `frame_start`)
- rom_orientation  out  4  to ROM orientation select; equals latched orientation
- rom_address  out  6  to ROM row address
- rom_data  in  WIDTH  ROM row bitmap; bit WIDTH-1 is the leftmost pixel
- pixel_on  out  1  sprite covers pixel (hcount,vcount) presented one cycle earlier
- busy  out  1  fetch FSM not IDLE
- overrun  out  1  sticky; set when `line_start` arrives while busy

Behaviour:
- Reset values:
  - all outputs 0.
  - latched pos/orientation/en = 0.
  - `row_buf` = 0.
  - FSM = IDLE.
  - Reset mid-fetch abandons the fetch.
- Frame latch: on `frame_start`, capture pos_x, pos_y, orientation_in and sprite_en.
  - If `frame_start` and `line_start` coincide, the fetch uses the newly latched values.
- Next line: nl = (vcount == V_TOTAL-1) ? 0 : vcount+1.
  - row = nl - pos_y_l, computed CW+1 bits wide with a sign bit.
  - In range iff sprite_en_l, row >= 0 and row < HEIGHT.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
  - IDLE → ISSUE on `line_start`.
    - If not in range, IDLE → CLEAR-path instead: `row_buf` <= 0 on the same edge and stay IDLE.
  - ISSUE: `rom_address` <= row[5:0]. Go to WAIT with wait counter = ROM_LAT.
  - WAIT: decrement the counter. At 0, go to CAPTURE.
  - CAPTURE: `row_buf` <= `rom_data`. Go to IDLE.
  - Total fetch = ROM_LAT+2 cycles after `line_start`.
  - `rom_address` holds its last value outside ISSUE.
- `line_start` while busy: ignore it, set `overrun`. `overrun` clears only on reset.
- Pixel output, registered:
  - `pixel_on` <= in_x && hcount < H_ACTIVE && row_buf[WIDTH-1-col].
  - in_x = hcount >= pos_x_l && hcount < pos_x_l+WIDTH, with the sum in CW+1 bits.
  - col = hcount - pos_x_l.
  - Latency is one cycle.
- The sprite extending past line V_TOTAL-1 or column H_ACTIVE-1 is clipped, never wrapped.
- Row 0 is drawn on line pos_y_l. The line buffer for line L is loaded in the hblank of line L-1.
- Line 0 is fetched in the hblank of line V_TOTAL-1, using the values latched at the `frame_start` that precedes it.

Optional Feature:
- Macro: SHAPE_ROW_RENDER_MIRROR_EN.
- Defined:
  - Adds input `mirror_x` (1 bit), latched on `frame_start`.
  - When the latch is 1, `pixel_on` uses row_buf[col] (horizontal flip).
- Undefined: no port, no mirroring logic, and behaviour exactly as above.

Decomposition:
- Shared package `shape_pkg`:
  - SHAPE_WIDTH=51, SHAPE_HEIGHT=60, SHAPE_ADDR_W=6, ORIENT_W=4.
  - Fetch FSM state enum {IDLE, ISSUE, WAIT, CAPTURE}.
  - Defaults for the display timing constants.
- One sub-module: `shape_row_serializer`.
  - Holds `row_buf` plus the column compare/select and `pixel_on` register.
  - The FSM and frame latch stay in the top module.

Test Plan:
- Setup: pos=(100,200), orient 0, bench ROM loaded with the orientation-0 table, ROM_LAT=1.
  - Line 200: `pixel_on` = 1 only for hcount=125 (row 0 is bit 25), observed one cycle later.
- Line 215 (row 15, all ones): `pixel_on` high for hcount 100..150 (51 cycles).
  - Line 223 (row 23): no pixels.
  - Line 260 (row 60, out of range): `row_buf` cleared, no pixels.
- Change pos_y to 10 mid-frame: the current frame is unchanged. After the next `frame_start`, the first hit is on line 10.
- pos_x=620: pixels only at hcount 620..639 for line rows of all ones; none at ≥640.
  - pos_y=520: line 524 drawn (row 4), line 0 not drawn (no vertical wrap).
- Assert `line_start` again 2 cycles after a fetch begins: `overrun`=1, first fetch completes, `busy` falls 3 cycles after the first `line_start`.
  - Assert `rst_n`=0 mid-WAIT: `busy`, `pixel_on` and `overrun` immediately 0.
- MIRROR_EN defined, mirror_x=1, row 1 (bits 27..23 set): `pixel_on` at hcount 123..127 for pos_x=100.
  - Asymmetric ROM pattern bit 50 only: hit at hcount 150 instead of 100.
